// File: rtl/sysa_array.sv
// Weight-stationary NxN systolic matrix-vector engine with input skew, output deskew,
// valid tracking and ready/valid backpressure. Define SYSA_SAT_EN to saturate lane outputs to OW bits.
module sysa_array #(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int OW     = 16,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*N*DW-1:0] w,
    input  logic              w_load,
    output logic              w_ack,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*OW-1:0]   out_data,
    output logic              busy
);
    localparam int SW = 2*DW + $clog2(N);
    localparam int ST = 2*N;

    logic                          adv, acc;
    logic [ST-1:0]                 vld_q;
    logic [N*N*DW-1:0]             w_q;
    logic                          w_ack_q;
    logic [N-1:0][DW-1:0]          row_x;
    logic [N-1:0][N-2:0][DW-1:0]   x_q, x_d;
    logic [N-1:0][N-1:0][SW-1:0]   ps_q, ps_d;
    logic [N-1:0][SW-1:0]          col_s;
    logic [N-1:0][OW-1:0]          y_d, out_q;

    function automatic logic [SW-1:0] ext(input logic [DW-1:0] v);
        ext = (SIGNED != 0) ? {{(SW-DW){v[DW-1]}}, v} : {{(SW-DW){1'b0}}, v};
    endfunction

    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv && !w_load;
    assign acc       = in_valid && in_ready;
    assign out_valid = vld_q[ST-1];
    assign busy      = |vld_q;
    assign w_ack     = w_ack_q;
    assign out_data  = out_q;

    // Row i enters the array i advancing cycles late; unaccepted slots inject zeros.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_d0
            assign row_x[0] = acc ? in_data[DW-1:0] : '0;
        end else begin : g_dn
            logic [i-1:0][DW-1:0] sk_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sk_q <= '0;
                end else if (adv) begin
                    sk_q[0] <= acc ? in_data[i*DW +: DW] : '0;
                    for (int s = 1; s < i; s++) sk_q[s] <= sk_q[s-1];
                end
            end
            assign row_x[i] = sk_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0] xin;
            logic [SW-1:0] pin;
            if (j == 0) begin : g_xl
                assign xin = row_x[i];
            end else begin : g_xh
                assign xin = x_q[i][j-1];
            end
            if (i == 0) begin : g_pt
                assign pin = '0;
            end else begin : g_pi
                assign pin = ps_q[i-1][j];
            end
            if (j < N-1) begin : g_fw
                assign x_d[i][j] = xin;
            end
            assign ps_d[i][j] = pin + ext(xin) * ext(w_q[(i*N+j)*DW +: DW]);
        end
    end

    // Column j leaves the array j cycles after column 0; pad it back into alignment.
    for (genvar j = 0; j < N; j++) begin : g_dsk
        if (j == N-1) begin : g_d0
            assign col_s[j] = ps_q[N-1][j];
        end else begin : g_dn
            localparam int D = N-1-j;
            logic [D-1:0][SW-1:0] ds_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ds_q <= '0;
                end else if (adv) begin
                    ds_q[0] <= ps_q[N-1][j];
                    for (int s = 1; s < D; s++) ds_q[s] <= ds_q[s-1];
                end
            end
            assign col_s[j] = ds_q[D-1];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_out
        if (OW == SW) begin : g_eq
            assign y_d[j] = col_s[j];
        end else begin : g_nar
            logic [SW-OW-1:0] hi;
            assign hi = col_s[j][SW-1:OW];
`ifdef SYSA_SAT_EN
            if (SIGNED != 0) begin : g_s
                // In range iff every bit above the OW-bit sign bit replicates it.
                assign y_d[j] = (hi == {(SW-OW){col_s[j][OW-1]}}) ? col_s[j][OW-1:0]
                              : {col_s[j][SW-1], {(OW-1){~col_s[j][SW-1]}}};
            end else begin : g_u
                assign y_d[j] = (|hi) ? '1 : col_s[j][OW-1:0];
            end
`else
            logic unused_hi;
            assign unused_hi = ^hi;
            assign y_d[j]    = col_s[j][OW-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            ps_q    <= '0;
            x_q     <= '0;
            out_q   <= '0;
            w_q     <= '0;
            w_ack_q <= 1'b0;
        end else begin
            w_ack_q <= 1'b0;
            // Weights only change with nothing in flight; one ack per held request.
            if (w_load && !busy && !w_ack_q) begin
                w_q     <= w;
                w_ack_q <= 1'b1;
            end
            if (adv) begin
                vld_q <= {vld_q[ST-2:0], acc};
                ps_q  <= ps_d;
                x_q   <= x_d;
                out_q <= y_d;
            end
        end
    end
endmodule

// File: tb/tb_sysa_array.sv
// Bench for sysa_array: queue-based result model checked every cycle, plus directed literal checks.
module tb_sysa_array;
    localparam int N = 3, DW = 8, OW = 16, SIGNED = 1, LAT = 2*N;

    logic clk = 1'b0, rst = 1'b1;
    logic [N*N*DW-1:0] w = '0;
    logic w_load = 1'b0, w_ack, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [N*DW-1:0] in_data = '0;
    logic [N*OW-1:0] out_data;

    int checks = 0, errors = 0, consumed = 0;
    longint wm [N][N];
    logic [N*OW-1:0] last_out = '0;

    typedef struct { int age; logic [N*OW-1:0] y; } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    sysa_array #(.N(N), .DW(DW), .OW(OW), .SIGNED(SIGNED)) dut (
        .clk(clk), .rst(rst), .w(w), .w_load(w_load), .w_ack(w_ack),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        return (SIGNED != 0) ? longint'($signed(v)) : longint'({1'b0, v});
    endfunction

    function automatic logic [OW-1:0] fix(input longint s);
        longint r;
        r = s;
`ifdef SYSA_SAT_EN
        begin
            longint lo, hi;
            lo = (SIGNED != 0) ? -(longint'(1) <<< (OW-1)) : 0;
            hi = (SIGNED != 0) ? (longint'(1) <<< (OW-1)) - 1 : (longint'(1) <<< OW) - 1;
            if (r > hi) r = hi;
            else if (r < lo) r = lo;
        end
`endif
        return r[OW-1:0];
    endfunction

    function automatic logic [N*OW-1:0] model_y(input logic [N*DW-1:0] x);
        logic [N*OW-1:0] res;
        res = '0;
        for (int j = 0; j < N; j++) begin
            longint s;
            s = 0;
            for (int i = 0; i < N; i++) s += sx(x[i*DW +: DW]) * wm[i][j];
            res[j*OW +: OW] = fix(s);
        end
        return res;
    endfunction

    // Model: each accepted vector ages one step per advancing edge and is due at age LAT.
    logic prev_stall = 1'b0;
    logic [N*OW-1:0] prev_data = '0;
    always @(negedge clk) begin
        logic ev, adv;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
        end else begin
            ev = (q.size() > 0) && (q[0].age == LAT);
            chk("out_valid", out_valid, ev);
            if (ev) chk("out_data", out_data, q[0].y);
            chk("busy", busy, q.size() > 0);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", out_data, prev_data);
            end
            adv = !(ev && !out_ready);
            chk("in_ready", in_ready, adv && !w_load);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (adv) begin
                if (ev) begin
                    last_out = out_data;
                    void'(q.pop_front());
                    consumed++;
                end
                foreach (q[k]) q[k].age++;
                if (in_valid && !w_load) q.push_back('{age: 1, y: model_y(in_data)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [N*N*DW-1:0] nw, input int exp_wait, input string tag);
        int cnt;
        w = nw;
        w_load = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!w_ack && cnt < 50);
        chk({tag, "_ack_wait"}, cnt, exp_wait);
        w_load = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wm[i][j] = sx(nw[(i*N+j)*DW +: DW]);
        tick();
        chk({tag, "_ack_pulse"}, w_ack, 0);
    endtask

    task automatic send1(input logic [N*DW-1:0] x);
        in_data = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t);
        t = 1;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N*N*DW-1:0] wk, wid, wneg;
        int t, c0;
        logic got;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wm[i][j] = 0;
                wk[(i*N+j)*DW +: DW]   = 8'(3*i + j + 1);
                wid[(i*N+j)*DW +: DW]  = (i == j) ? 8'd1 : 8'd0;
                wneg[(i*N+j)*DW +: DW] = 8'h80;
            end

        // Reset values
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_w_ack", w_ack, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Known matrix and exact latency
        load_w(wk, 1, "known");
        send1({8'd3, 8'd2, 8'd1});
        wait_out(t);
        chk("known_latency", t, LAT);
        chk("known_y", out_data, {16'd42, 16'd36, 16'd30});
        tick();

        // Streaming with a bubble
        load_w(wid, 1, "ident");
        in_data = {8'd7, 8'd6, 8'd5}; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        in_data = {8'hFD, 8'hFE, 8'hFF}; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("bubble_v0", out_valid, 1);
        chk("bubble_y0", out_data, {16'd7, 16'd6, 16'd5});
        tick();
        chk("bubble_gap", out_valid, 0);
        tick();
        chk("bubble_v1", out_valid, 1);
        chk("bubble_y1", out_data, {16'hFFFD, 16'hFFFE, 16'hFFFF});
        tick(); tick();

        // Backpressure: out_ready toggles every cycle
        c0 = consumed;
        for (int v = 0; v < 8; v++) begin
            in_data = {8'(2*v), 8'(-v), 8'(v + 1)};
            in_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                out_ready = ~out_ready;
                #1 got = in_ready;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 100 && (consumed - c0) < 8; k++) begin
            out_ready = ~out_ready;
            tick();
        end
        chk("bp_count", consumed - c0, 8);
        out_ready = 1'b1;
        tick(); tick();

        // Weight guard: load requested while a vector is in flight
        load_w(wk, 1, "guard_pre");
        send1({8'd1, 8'd1, 8'd1});
        tick(); tick();
        load_w(wid, 5, "guard");
        chk("guard_old_w", last_out, {16'd18, 16'd15, 16'd12});
        send1({8'd6, 8'd5, 8'd4});
        wait_out(t);
        chk("guard_new_w", out_data, {16'd6, 16'd5, 16'd4});
        tick();

        // Overflow
        load_w(wneg, 1, "ovf");
        send1({8'h80, 8'h80, 8'h80});
        wait_out(t);
`ifdef SYSA_SAT_EN
        chk("ovf_y", out_data, {3{16'h7FFF}});
`else
        chk("ovf_y", out_data, {3{16'hC000}});
`endif
        tick();

        // Reset mid-stream
        load_w(wk, 1, "prerst");
        for (int v = 0; v < 4; v++) begin
            in_data = {8'(v), 8'(v + 2), 8'(v + 1)};
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1 chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_busy", busy, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wm[i][j] = 0;
        for (int k = 0; k < 10; k++) tick();
        send1({8'd3, 8'd2, 8'd1});
        wait_out(t);
        chk("rst_latency", t, LAT);
        chk("rst_zero_w", out_data, 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysa_array.md
Name: sysa_array

Overview:
- Parametrised weight-stationary NxN systolic matrix-vector engine; successor to the fixed 3x3 array.
- Each accepted input vector x (N lanes) produces one output vector y, with y[j] = sum over i of x[i]*W[i][j].
- Adds what the fixed array lacks: internal input skew and output deskew, valid tracking, ready/valid backpressure, guarded weight loading, signed/unsigned mode and configurable output width.
- Sits between the activation buffer (upstream) and the result writeback (downstream) in the eTPU datapath.

Parameters:
- N, 3, array dimension (rows = input lanes, columns = output lanes); legal range 2..8.
- DW, 8, width of input and weight elements.
- OW, 16, width of each output lane. Internal sum width is SW = 2*DW + clog2(N); OW must be <= SW.
- SIGNED, 1, 1 = two's-complement operands and sums; 0 = unsigned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- w  in  N*N*DW  weight matrix; W[i][j] = w[(i*N+j)*DW +: DW].
- w_load  in  1  request to latch w into the stationary weight registers.
- w_ack  out  1  one-cycle pulse: w was latched on this edge.
- in_valid  in  1  in_data holds a vector.
- in_ready  out  1  array accepts a vector this cycle.
- in_data  in  N*DW  x[i] = in_data[i*DW +: DW], unskewed; all lanes are presented together.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N*OW  y[j] = out_data[j*OW +: OW], deskewed; all lanes are aligned.
- busy  out  1  at least one valid vector is in flight or held at the output.

Behaviour:
- Reset (async assert, sync release):
  - Weights, skew/deskew registers, PE registers and the valid pipeline all clear to 0.
  - out_valid=0, out_data=0, w_ack=0, busy=0.
- Advance condition:
  - stall = out_valid && !out_ready.
  - adv = !stall. All pipeline, skew, deskew and PE registers update only when adv=1; otherwise they hold.
- Input acceptance:
  - in_ready = adv && !w_load.
  - A vector is accepted when in_valid && in_ready.
  - When in_valid=0 (a bubble), zeros are injected with valid=0. Bubbles are preserved in order.
- Datapath:
  - Row i input is delayed i advancing cycles by the skew chain.
  - PE(i,j) registers its horizontal operand and computes psum_out = psum_in + x*W[i][j]. Row 0 has psum_in = 0.
  - Column j bottom output is delayed N-1-j advancing cycles by the deskew chain, then passes through the output register.
- Latency:
  - A vector accepted on advancing edge k appears on out_data with out_valid=1 immediately after advancing edge k+2N-1.
  - That is 2N advancing edges, counting the acceptance edge.
  - Full throughput: one vector per cycle while out_ready=1.
- Valid tracking:
  - A 2N-deep valid shift register advances with adv.
  - out_valid is its last stage.
  - busy = OR of all stages.
- Output handshake:
  - out_data is stable while out_valid && !out_ready.
  - The result is consumed on an edge where out_valid && out_ready.
- Arithmetic:
  - Products and sums are computed at SW bits; signed or unsigned per SIGNED.
  - The OW-bit output is derived from the SW-bit sum per the optional feature below.
- Weight load:
  - Accepted only when w_load && !busy. On that edge W <= w and w_ack pulses for 1 cycle.
  - w_load while busy=1 is ignored: no ack, weights unchanged. Requester must hold w_load until w_ack.
  - w_load and in_valid in the same idle cycle: weight load wins; in_ready=0 that cycle.
- Reset mid-stream: all in-flight vectors are discarded. No out_valid appears until new vectors are accepted after release.

Optional Feature:
- Macro: SYSA_SAT_EN.
- Defined:
  - Each SW-bit lane sum saturates to the OW range.
  - Signed range: [-2^(OW-1), 2^(OW-1)-1]. Unsigned range: [0, 2^OW-1].
- Undefined: each lane output is the low OW bits of the SW-bit sum (wrap-around).
- When OW == SW, both builds are identical.

Test Plan:
- Known matrix: N=3, DW=8, OW=16, SIGNED=1, W[i][j]=3i+j+1; load, then x=(1,2,3) -> w_ack pulse; y=(30,36,42) after exactly 6 edges.
- Streaming with bubbles: W=identity; x=(5,6,7), bubble, x=(-1,-2,-3) on consecutive cycles -> outputs (5,6,7), then a 1-cycle out_valid=0 gap, then (-1,-2,-3).
- Backpressure: stream 8 vectors with out_ready toggling every cycle -> all 8 results in order, none lost or duplicated, out_data stable during each stall.
- Weight guard: w_load asserted 2 cycles after a vector enters -> no w_ack until busy falls; that vector uses the old weights; the next vector uses the new weights.
- Overflow: SIGNED=1, all weights = -128, x=(-128,-128,-128), so sum = 49152 -> 32767 (0x7FFF) with SYSA_SAT_EN; 0xC000 (-16384) without.
- Reset mid-stream: assert rst with 4 vectors in flight -> out_valid=0 and busy=0 immediately (asynchronously); no stale results after release; weights read back as 0 (y=(0,0,0)).
